// File: rtl/operand_fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// operand_fetch_sequencer_if
//
// Shared data-cache read port used by the operand fetch sequencer.
//
// Handshake: the master raises memReqOut with memAddrOut and holds both
// unchanged until the slave returns memAckIn. The request is never withdrawn
// before its ack. memAckIn is sampled on the rising clock edge and may be high
// in the first cycle memReqOut is high (zero-wait). memDataIn is valid only
// in a cycle where memAckIn is high. memAckIn has no meaning while memReqOut
// is low.
//
// Signals:
//   memReqOut   master -> slave  read request
//   memAddrOut  master -> slave  [0:ADDR_W-1] read address
//   memAckIn    slave -> master  read completes this cycle
//   memDataIn   slave -> master  [0:ADDR_W-1] read data, valid with memAckIn
// ---------------------------------------------------------------------------
interface operand_fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              memReqOut;
    logic [0:ADDR_W-1] memAddrOut;
    logic              memAckIn;
    logic [0:ADDR_W-1] memDataIn;

    modport master (
        output memReqOut,
        output memAddrOut,
        input  memAckIn,
        input  memDataIn
    );

    modport slave (
        input  memReqOut,
        input  memAddrOut,
        output memAckIn,
        output memDataIn
    );
endinterface

// File: rtl/operand_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// operand_fetch_sequencer
//
// Latches the src1/src2/dest addresses of one instruction and issues the
// src1 and src2 memory reads one at a time over a single shared cache read
// port, then presents both operands to execute with doneOut. busyOut stalls
// the front of the pipe while the sequencer is not idle. A flush aborts the
// instruction; a request already on the cache port is drained (held until its
// ack, data discarded) so the cache never sees a request withdrawn.
//
// Optional feature macro: OPERAND_FETCH_DEDUP_EN
//   When defined, an instruction whose two memory sources share one address
//   issues a single read and copies the data into both operand registers.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   startIn                  instruction addresses valid (accepted in IDLE)
//   isMemoryAccessSrc1In/2In source needs a memory read
//   memoryAddressSrc1In/2In  source addresses
//   memoryAddressDestIn      destination address (passed through)
//   flushIn                  abort current instruction
//   consumerStallIn          execute stage cannot accept the result
//   memIf                    cache read port (master modport)
//   busyOut                  high in every state except IDLE
//   doneOut                  operands valid (DONE state)
//   operand1DataOut/2        captured read data
//   memoryAddressDestOut     latched destination address
//   stateOut                 current FSM state, for observation
// ---------------------------------------------------------------------------
module operand_fetch_sequencer #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              startIn,
    input  logic              isMemoryAccessSrc1In,
    input  logic              isMemoryAccessSrc2In,
    input  logic [0:ADDR_W-1] memoryAddressSrc1In,
    input  logic [0:ADDR_W-1] memoryAddressSrc2In,
    input  logic [0:ADDR_W-1] memoryAddressDestIn,
    input  logic              flushIn,
    input  logic              consumerStallIn,
    operand_fetch_sequencer_if.master memIf,
    output logic              busyOut,
    output logic              doneOut,
    output logic [0:ADDR_W-1] operand1DataOut,
    output logic [0:ADDR_W-1] operand2DataOut,
    output logic [0:ADDR_W-1] memoryAddressDestOut,
    output logic [2:0]        stateOut
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD1   = 3'd1;
    localparam logic [2:0] RD2   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        stateQ;
    logic [2:0]        stateD;
    logic              needSrc2Q;
    logic [0:ADDR_W-1] src2AddrQ;
    logic [0:ADDR_W-1] destAddrQ;
    // Address currently presented on the cache port. It is loaded with the
    // src1 address at start (so it doubles as the latched src1 address) and
    // switched to src2 only when the src1 read completes, which keeps it
    // stable across wait cycles and through DRAIN.
    logic [0:ADDR_W-1] memAddrQ;
    logic [0:ADDR_W-1] op1Q;
    logic [0:ADDR_W-1] op2Q;
    logic              goRd2;
    logic              startOk;

`ifdef OPERAND_FETCH_DEDUP_EN
    logic dupQ;
    assign goRd2 = needSrc2Q && !dupQ;
`else
    assign goRd2 = needSrc2Q;
`endif

    assign startOk = startIn && !flushIn;

    // Next-state logic. Flush outranks start, ack and consumer stall; an
    // unacknowledged read under flush must drain rather than drop the request.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (startOk) begin
                    if (isMemoryAccessSrc1In)      stateD = RD1;
                    else if (isMemoryAccessSrc2In) stateD = RD2;
                    else                           stateD = DONE;
                end
            end
            RD1: begin
                if (flushIn)             stateD = memIf.memAckIn ? IDLE : DRAIN;
                else if (memIf.memAckIn) stateD = goRd2 ? RD2 : DONE;
            end
            RD2: begin
                if (flushIn)             stateD = memIf.memAckIn ? IDLE : DRAIN;
                else if (memIf.memAckIn) stateD = DONE;
            end
            DRAIN: begin
                if (memIf.memAckIn) stateD = IDLE;
            end
            DONE: begin
                if (flushIn || !consumerStallIn) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= IDLE;
            needSrc2Q <= 1'b0;
            src2AddrQ <= '0;
            destAddrQ <= '0;
            memAddrQ  <= '0;
            op1Q      <= '0;
            op2Q      <= '0;
`ifdef OPERAND_FETCH_DEDUP_EN
            dupQ      <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            case (stateQ)
                IDLE: begin
                    if (startOk) begin
                        needSrc2Q <= isMemoryAccessSrc2In;
                        src2AddrQ <= memoryAddressSrc2In;
                        destAddrQ <= memoryAddressDestIn;
                        memAddrQ  <= isMemoryAccessSrc1In ? memoryAddressSrc1In
                                                          : memoryAddressSrc2In;
                        // Sources without a memory read present zero.
                        if (!isMemoryAccessSrc1In) op1Q <= '0;
                        if (!isMemoryAccessSrc2In) op2Q <= '0;
`ifdef OPERAND_FETCH_DEDUP_EN
                        dupQ <= isMemoryAccessSrc1In && isMemoryAccessSrc2In &&
                                (memoryAddressSrc1In == memoryAddressSrc2In);
`endif
                    end
                end
                RD1: begin
                    // Data arriving alongside a flush is discarded.
                    if (memIf.memAckIn && !flushIn) begin
                        op1Q     <= memIf.memDataIn;
                        memAddrQ <= src2AddrQ;
`ifdef OPERAND_FETCH_DEDUP_EN
                        if (dupQ) op2Q <= memIf.memDataIn;
`endif
                    end
                end
                RD2: begin
                    if (memIf.memAckIn && !flushIn) op2Q <= memIf.memDataIn;
                end
                default: ;
            endcase
        end
    end

    assign memIf.memReqOut  = (stateQ == RD1) || (stateQ == RD2) || (stateQ == DRAIN);
    assign memIf.memAddrOut = memAddrQ;

    assign busyOut              = (stateQ != IDLE);
    assign doneOut              = (stateQ == DONE);
    assign operand1DataOut      = op1Q;
    assign operand2DataOut      = op2Q;
    assign memoryAddressDestOut = destAddrQ;
    assign stateOut             = stateQ;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_sequencer
//
// Directed bench for operand_fetch_sequencer. A cache responder serves reads
// from a small table with a configurable number of wait cycles and checks
// every request against the expected request queue; a done monitor checks
// each completed instruction against the expected-result queue.
// ---------------------------------------------------------------------------
module tb_operand_fetch_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD2   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;

    typedef struct {
        logic [0:63] op1;
        logic [0:63] op2;
        logic [0:63] dest;
        int          doneCyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        startIn;
    logic        isMemoryAccessSrc1In;
    logic        isMemoryAccessSrc2In;
    logic [0:63] memoryAddressSrc1In;
    logic [0:63] memoryAddressSrc2In;
    logic [0:63] memoryAddressDestIn;
    logic        flushIn;
    logic        consumerStallIn;
    logic        busyOut;
    logic        doneOut;
    logic [0:63] operand1DataOut;
    logic [0:63] operand2DataOut;
    logic [0:63] memoryAddressDestOut;
    logic [2:0]  stateOut;

    operand_fetch_sequencer_if #(.ADDR_W(64)) cacheIf ();

    operand_fetch_sequencer #(.ADDR_W(64)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .startIn              (startIn),
        .isMemoryAccessSrc1In (isMemoryAccessSrc1In),
        .isMemoryAccessSrc2In (isMemoryAccessSrc2In),
        .memoryAddressSrc1In  (memoryAddressSrc1In),
        .memoryAddressSrc2In  (memoryAddressSrc2In),
        .memoryAddressDestIn  (memoryAddressDestIn),
        .flushIn              (flushIn),
        .consumerStallIn      (consumerStallIn),
        .memIf                (cacheIf),
        .busyOut              (busyOut),
        .doneOut              (doneOut),
        .operand1DataOut      (operand1DataOut),
        .operand2DataOut      (operand2DataOut),
        .memoryAddressDestOut (memoryAddressDestOut),
        .stateOut             (stateOut)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    exp_t        expQ[$];
    logic [0:63] expReqQ[$];
    logic [0:63] memTbl [logic [0:63]];
    logic [0:63] lastOp1 = '0;
    logic [0:63] lastOp2 = '0;
    int          waitCfg = 0;

    task automatic check(input string tag, input logic [0:63] obs, input logic [0:63] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:63] memData(input logic [0:63] a);
        if (memTbl.exists(a)) return memTbl[a];
        return {a[32:63], ~a[0:31]};
    endfunction

    // ---------------- cache responder ----------------
    bit          inReq = 0;
    int          waitCnt = 0;
    logic [0:63] reqAddr = '0;

    initial begin
        cacheIf.memAckIn  = 1'b0;
        cacheIf.memDataIn = '0;
    end

    always @(negedge clk) begin
        if (cacheIf.memReqOut) begin
            if (!inReq) begin
                inReq   = 1;
                waitCnt = 0;
                reqAddr = cacheIf.memAddrOut;
                check("req_expected", 64'(expReqQ.size() != 0), 64'd1);
                if (expReqQ.size() != 0) check("req_addr", cacheIf.memAddrOut, expReqQ.pop_front());
            end else begin
                check("req_stable", cacheIf.memAddrOut, reqAddr);
            end
            if (waitCnt >= waitCfg) begin
                cacheIf.memAckIn  = 1'b1;
                cacheIf.memDataIn = memData(cacheIf.memAddrOut);
                inReq = 0;
            end else begin
                cacheIf.memAckIn  = 1'b0;
                cacheIf.memDataIn = {$urandom, $urandom};
                waitCnt++;
            end
        end else begin
            cacheIf.memAckIn  = 1'b0;
            cacheIf.memDataIn = {$urandom, $urandom};
            inReq = 0;
        end
    end

    // ---------------- done monitor ----------------
    bit doneSeen = 0;
    always @(negedge clk) begin
        if (reset_n && doneOut && !doneSeen) begin
            check("done_expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                exp_t e;
                e = expQ.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.doneCyc));
                check("operand1", operand1DataOut, e.op1);
                check("operand2", operand2DataOut, e.op2);
                check("dest_addr", memoryAddressDestOut, e.dest);
            end
        end
        doneSeen = doneOut;
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns one cycle later (first cycle after
    // start was sampled) with startIn deasserted.
    task automatic issue(input logic f1, input logic f2, input logic [0:63] a1,
                         input logic [0:63] a2, input logic [0:63] ad,
                         input int waits, input bit expectDone);
        exp_t e;
        bit   dup;
        int   lat;
        dup = 0;
`ifdef OPERAND_FETCH_DEDUP_EN
        dup = f1 && f2 && (a1 == a2);
`endif
        waitCfg = waits;
        if (f1) expReqQ.push_back(a1);
        if (f2 && !dup) expReqQ.push_back(a2);
        lat = 1 + (f1 ? waits + 1 : 0) + ((f2 && !dup) ? waits + 1 : 0);
        e.op1     = f1 ? memData(a1) : 64'd0;
        e.op2     = f2 ? memData(a2) : 64'd0;
        e.dest    = ad;
        e.doneCyc = cyc + lat;
        if (!f1) lastOp1 = '0;
        if (!f2) lastOp2 = '0;
        if (expectDone) begin
            expQ.push_back(e);
            lastOp1 = e.op1;
            lastOp2 = e.op2;
        end
        startIn              = 1'b1;
        isMemoryAccessSrc1In = f1;
        isMemoryAccessSrc2In = f2;
        memoryAddressSrc1In  = a1;
        memoryAddressSrc2In  = a2;
        memoryAddressDestIn  = ad;
        @(negedge clk);
        startIn              = 1'b0;
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        memoryAddressSrc1In  = '0;
        memoryAddressSrc2In  = '0;
        memoryAddressDestIn  = '0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busyOut && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busyOut), 64'd0);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!doneOut && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(doneOut), 64'd1);
    endtask

    task automatic waitState(input logic [2:0] s, input int budget);
        int n = 0;
        while (stateOut != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("state_timeout", 64'(stateOut), 64'(s));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_req"},   64'(cacheIf.memReqOut), 64'd0);
        check({tag, "_addr"},  cacheIf.memAddrOut, 64'd0);
        check({tag, "_busy"},  64'(busyOut), 64'd0);
        check({tag, "_done"},  64'(doneOut), 64'd0);
        check({tag, "_op1"},   operand1DataOut, 64'd0);
        check({tag, "_op2"},   operand2DataOut, 64'd0);
        check({tag, "_dest"},  memoryAddressDestOut, 64'd0);
        check({tag, "_state"}, 64'(stateOut), 64'(S_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic        rf1;
        logic        rf2;
        logic [0:63] ra1;
        logic [0:63] ra2;

        reset_n              = 1'b0;
        startIn              = 1'b0;
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        memoryAddressSrc1In  = '0;
        memoryAddressSrc2In  = '0;
        memoryAddressDestIn  = '0;
        flushIn              = 1'b0;
        consumerStallIn      = 1'b0;
        memTbl[64'h1000] = 64'hDEAD;
        memTbl[64'h2000] = 64'h1111_2222_3333_4444;
        memTbl[64'h2008] = 64'h5555_6666_7777_8888;
        memTbl[64'h4000] = 64'h0123_4567_89AB_CDEF;

        #1;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Src1 only, zero-wait: one request cycle, done at cycle 2.
        issue(1'b1, 1'b0, 64'h1000, 64'h0, 64'h1010, 0, 1'b1);
        check("s1_req_c1", 64'(cacheIf.memReqOut), 64'd1);
        check("s1_busy_c1", 64'(busyOut), 64'd1);
        @(negedge clk);
        check("s1_req_c2", 64'(cacheIf.memReqOut), 64'd0);
        waitIdle(10);

        // Flush during an RD1 wait: drain holds request until ack, no done,
        // operand1 keeps 0xDEAD even though the drained read returns 0xBEEF.
        memTbl[64'h1000] = 64'hBEEF;
        issue(1'b1, 1'b0, 64'h1000, 64'h0, 64'h1020, 3, 1'b0);
        flushIn = 1'b1;
        @(negedge clk);
        flushIn = 1'b0;
        check("drain_state", 64'(stateOut), 64'(S_DRAIN));
        check("drain_req", 64'(cacheIf.memReqOut), 64'd1);
        check("drain_addr", cacheIf.memAddrOut, 64'h1000);
        @(negedge clk);
        check("drain_req2", 64'(cacheIf.memReqOut), 64'd1);
        waitIdle(10);
        check("drain_op1", operand1DataOut, lastOp1);
        check("drain_op2", operand2DataOut, lastOp2);

        // Flush in RD1 together with a zero-wait ack: data discarded, to IDLE.
        issue(1'b1, 1'b0, 64'h1000, 64'h0, 64'h1030, 0, 1'b0);
        flushIn = 1'b1;
        @(negedge clk);
        flushIn = 1'b0;
        check("flushack_state", 64'(stateOut), 64'(S_IDLE));
        check("flushack_op1", operand1DataOut, lastOp1);

        // Both sources with 3 wait cycles, ignored start pulses while busy.
        issue(1'b1, 1'b1, 64'h2000, 64'h2008, 64'h2010, 3, 1'b1);
        @(negedge clk);
        startIn              = 1'b1;
        isMemoryAccessSrc1In = 1'b1;
        memoryAddressSrc1In  = 64'h9999;
        @(negedge clk);
        startIn              = 1'b0;
        isMemoryAccessSrc1In = 1'b0;
        repeat (3) @(negedge clk);
        startIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        memoryAddressSrc1In = '0;
        waitIdle(20);

        // No memory sources: done at cycle 1, dest passed through.
        issue(1'b0, 1'b0, 64'h0, 64'h0, 64'h3000, 0, 1'b1);
        check("nomem_done_c1", 64'(doneOut), 64'd1);
        waitIdle(10);

        // Equal source addresses (dedup build issues one read).
        issue(1'b1, 1'b1, 64'h4000, 64'h4000, 64'h4010, 0, 1'b1);
        waitIdle(10);

        // Flush while in DONE under consumer stall: doneOut drops next cycle.
        consumerStallIn = 1'b1;
        issue(1'b0, 1'b0, 64'h0, 64'h0, 64'h5000, 0, 1'b1);
        flushIn = 1'b1;
        @(negedge clk);
        flushIn = 1'b0;
        consumerStallIn = 1'b0;
        check("flushdone_done", 64'(doneOut), 64'd0);
        check("flushdone_state", 64'(stateOut), 64'(S_IDLE));

        // Random instructions.
        for (int i = 0; i < 6; i++) begin
            rf1 = 1'($urandom_range(0, 1));
            rf2 = 1'($urandom_range(0, 1));
            ra1 = {$urandom, $urandom};
            ra2 = ($urandom_range(0, 1) == 1) ? ra1 : {$urandom, $urandom};
            issue(rf1, rf2, ra1, ra2, {$urandom, $urandom}, $urandom_range(0, 3), 1'b1);
            waitIdle(20);
        end

        // Consumer stall holds DONE for 4 cycles.
        consumerStallIn = 1'b1;
        issue(1'b1, 1'b1, 64'h6000, 64'h6008, 64'h6010, 0, 1'b1);
        waitDone(10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_done", 64'(doneOut), 64'd1);
            check("stall_op1", operand1DataOut, lastOp1);
            check("stall_op2", operand2DataOut, lastOp2);
            check("stall_dest", memoryAddressDestOut, 64'h6010);
        end
        consumerStallIn = 1'b0;
        @(negedge clk);
        check("stall_release", 64'(busyOut), 64'd0);

        // Reset asserted mid-RD2: every output drops immediately.
        issue(1'b1, 1'b1, 64'h7000, 64'h7008, 64'h7010, 2, 1'b1);
        waitState(S_RD2, 20);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        void'(expQ.pop_back());
        lastOp1 = '0;
        lastOp2 = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("postreset_state", 64'(stateOut), 64'(S_IDLE));

        // One instruction after reset to show normal operation resumes.
        issue(1'b0, 1'b1, 64'h0, 64'h2008, 64'h8000, 1, 1'b1);
        waitIdle(10);

        repeat (2) @(negedge clk);
        check("exp_queue_empty", 64'(expQ.size()), 64'd0);
        check("req_queue_empty", 64'(expReqQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/operand_fetch_sequencer.md
# operand_fetch_sequencer

Sequences the memory-operand reads that follow address calculation. It latches the src1, src2 and dest addresses produced for one instruction and issues the src1 and src2 reads one at a time over a single shared data-cache read port. It then presents both operand values to the execute stage with a done pulse. While it works it stalls the front of the pipe, and it supports pipeline flush with a safe drain of any outstanding request.

## Interface
Parameters:
- ADDR_W, 64, width of memory addresses and of read data.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  single clock, rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
- Issue side (from address calculation):
  - startIn  in  1  one instruction's addresses are valid this cycle.
  - isMemoryAccessSrc1In / isMemoryAccessSrc2In  in  1 each  source operand needs a memory read.
  - memoryAddressSrc1In / memoryAddressSrc2In / memoryAddressDestIn  in  [0:63] each  computed addresses.
- Pipeline control:
  - flushIn  in  1  abort the current instruction.
  - consumerStallIn  in  1  execute stage cannot accept the result.
- Cache read port:
  - memReqOut  out  1  read request.
  - memAddrOut  out  [0:63]  read address.
  - memAckIn  in  1  read completes this cycle.
  - memDataIn  in  [0:63]  read data, valid with memAckIn.
- Status and results (to execute):
  - busyOut  out  1  high in every state except IDLE; upstream must stall.
  - doneOut  out  1  operands valid.
  - operand1DataOut / operand2DataOut  out  [0:63] each  read data.
  - memoryAddressDestOut  out  [0:63]  latched dest address, passed through.

## Operation
- States: IDLE, RD1, RD2, DRAIN, DONE. Registered state.
- IDLE, on startIn=1 and flushIn=0:
  - Latch all three addresses and both flags.
  - Next state: RD1 if src1 flag set; else RD2 if src2 flag set; else DONE.
- RD1:
  - memReqOut=1, memAddrOut=src1 address, held stable until ack.
  - On memAckIn: capture memDataIn into operand1DataOut; go to RD2 if src2 flag set, else DONE.
- RD2:
  - Same as RD1, using the src2 address and capturing into operand2DataOut; then DONE.
- DONE:
  - doneOut=1.
  - consumerStallIn=1: stay in DONE, outputs held.
  - consumerStallIn=0: go to IDLE next cycle.
- Operand registers for sources without a memory access are cleared to 0 at start.
- startIn outside IDLE is ignored; no queuing.
- Flush (priority over start, ack and consumerStallIn):
  - In IDLE or DONE: go to IDLE; doneOut drops next cycle.
  - In RD1/RD2 with memAckIn=1 in the same cycle: data is discarded; go to IDLE.
  - In RD1/RD2 without ack: go to DRAIN.
- DRAIN:
  - memReqOut stays 1 with the address unchanged until memAckIn; the data is discarded; then IDLE.
  - flushIn in DRAIN has no additional effect.
  - The cache never sees a request withdrawn before its ack.
- Address arithmetic: none. Addresses pass through unmodified at full 64 bits.

## Timing
- Reset (async assert, sync deassert used by system): state=IDLE; every output 0, including memReqOut, busyOut, doneOut, memAddrOut, both operand registers and memoryAddressDestOut.
- Reset mid-request drops memReqOut immediately. The cache side is reset by the same signal.
- memAckIn is sampled on the rising edge and may be high in the first cycle memReqOut is high (zero-wait).
- Latency with start at cycle 0:
  - Two reads, zero-wait: RD1 in cycle 1, RD2 in cycle 2, doneOut in cycle 3.
  - No reads: doneOut in cycle 1.
  - Each wait cycle on the cache adds one cycle.
- busyOut is high from cycle 1 through the last DONE cycle.
- Back-to-back throughput: one instruction per (reads + 2) cycles minimum.

## Configuration
- OPERAND_FETCH_DEDUP_EN:
  - Defined: when both src flags are set and the src1 and src2 addresses are equal, RD2 is skipped. After RD1, operand2DataOut receives the same data and the FSM goes directly to DONE (two reads finish in 2 cycles instead of 3).
  - Undefined: two independent reads are always issued.

## Test plan
- Src1 only, addr 0x1000, cache acks in the same cycle with 0xDEAD -> memReqOut for 1 cycle; doneOut at cycle 2 with operand1DataOut=0xDEAD, operand2DataOut=0.
- Both sources, addrs 0x2000/0x2008, 3 wait cycles each -> two requests in order, each address stable until its ack; doneOut at cycle 9; startIn pulses during busy are ignored.
- No memory sources, dest 0x3000 -> doneOut at cycle 1, memoryAddressDestOut=0x3000, memReqOut never asserted.
- flushIn during RD1 wait, ack 2 cycles later -> DRAIN keeps memReqOut=1 with 0x1000 until ack; IDLE next; no doneOut; operands unchanged.
- Both sources at equal address 0x4000 -> with OPERAND_FETCH_DEDUP_EN, one request and doneOut at cycle 2 with both operands equal; without the macro, two requests and doneOut at cycle 3.
- consumerStallIn held for 4 cycles in DONE, then reset_n pulsed low mid-RD2 on the next instruction -> DONE and outputs held 4 cycles; on reset, all outputs 0 immediately and state is IDLE.
